onehot_decoder_pipe: RTL and testbench

ONEHOT_DECODER_PIPE -- requirements
Module: onehot_decoder_pipe

---
 rtl/onehot_decoder_pipe.sv | 109 ++++++++++
 tb/tb_onehot_decoder_pipe.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/onehot_decoder_pipe.sv
// One-hot code decoder feeding a 2-entry result FIFO.
// Multi-bit codes decode to their highest set bit, as an MSB-first priority encoder would.
module onehot_decoder_pipe #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  in_code,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [IW-1:0] out_idx,
    output logic          out_zero,
    output logic          out_err,
    output logic [7:0]    err_cnt
);

    localparam int EW = IW + 2;  // entry layout: {idx, zero, err}

    logic [IW-1:0] dec_idx;
    logic          dec_zero;
    logic          dec_err;
    logic          dec_seen;

    always_comb begin
        dec_idx  = '0;
        dec_seen = 1'b0;
        dec_err  = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (in_code[i]) begin
                if (dec_seen) begin
                    dec_err = 1'b1;
                end
                dec_seen = 1'b1;
                dec_idx  = IW'(i);
            end
        end
        dec_zero = !dec_seen;
    end

    logic [EW-1:0] mem_q [2];
    logic [EW-1:0] mem_d [2];
    logic [1:0]    count_q, count_d;
    logic          wr_ptr_q, wr_ptr_d;
    logic          rd_ptr_q, rd_ptr_d;
    logic [7:0]    err_cnt_q, err_cnt_d;
    logic          push;
    logic          pop;
    logic [EW-1:0] head;

    assign in_ready  = (count_q != 2'd2) && resetn;
    assign out_valid = (count_q != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign head      = mem_q[rd_ptr_q];

    // Payload is gated so an empty FIFO reads as all zeros regardless of stale storage.
    assign out_idx  = out_valid ? head[EW-1:2] : '0;
    assign out_zero = out_valid && head[1];
    assign out_err  = out_valid && head[0];
    assign err_cnt  = err_cnt_q;

    always_comb begin
        mem_d[0]  = mem_q[0];
        mem_d[1]  = mem_q[1];
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        err_cnt_d = err_cnt_q;
        if (push) begin
            mem_d[wr_ptr_q] = {dec_idx, dec_zero, dec_err};
            wr_ptr_d        = !wr_ptr_q;
            if (dec_err && (err_cnt_q != 8'hFF)) begin
                err_cnt_d = err_cnt_q + 8'd1;
            end
        end
        if (pop) begin
            rd_ptr_d = !rd_ptr_q;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            count_q   <= 2'd0;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            err_cnt_q <= 8'd0;
        end else begin
            count_q   <= count_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    // Storage needs no reset: it is only observed through a nonzero count.
    always_ff @(posedge clk) begin
        mem_q[0] <= mem_d[0];
        mem_q[1] <= mem_d[1];
    end

endmodule

// File: tb/tb_onehot_decoder_pipe.sv
// Directed-vector bench for onehot_decoder_pipe; inputs change and outputs are sampled on the falling edge.
module tb_onehot_decoder_pipe;

    logic       clk = 1'b0;
    logic       resetn;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_code;
    logic       out_valid;
    logic       out_ready;
    logic [1:0] out_idx;
    logic       out_zero;
    logic       out_err;
    logic [7:0] err_cnt;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    onehot_decoder_pipe #(.N(4), .IW(2)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_code   (in_code),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_zero  (out_zero),
        .out_err   (out_err),
        .err_cnt   (err_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_out(input string tag, input logic v, input logic [1:0] idx,
                             input logic z, input logic e);
        check({tag, ".valid"}, 32'(out_valid), 32'(v));
        check({tag, ".idx"},   32'(out_idx),   32'(idx));
        check({tag, ".zero"},  32'(out_zero),  32'(z));
        check({tag, ".err"},   32'(out_err),   32'(e));
    endtask

    initial begin
        resetn    = 1'b0;
        in_valid  = 1'b0;
        in_code   = 4'b0000;
        out_ready = 1'b0;
        tick();
        tick();
        check_out("reset", 1'b0, 2'd0, 1'b0, 1'b0);
        check("reset.in_ready", 32'(in_ready), 32'd0);
        check("reset.err_cnt", 32'(err_cnt), 32'd0);
        resetn = 1'b1;
        #1;
        check("release.in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);

        // single code, latency one cycle
        in_valid = 1'b1; in_code = 4'b0100; out_ready = 1'b1;
        tick();
        check_out("single", 1'b1, 2'd2, 1'b0, 1'b0);
        in_valid = 1'b0;
        tick();
        check("single.drain", 32'(out_valid), 32'd0);

        // backpressure fills the FIFO, then drains in order
        out_ready = 1'b0;
        in_valid = 1'b1; in_code = 4'b0001;
        tick();
        check_out("bp.first", 1'b1, 2'd0, 1'b0, 1'b0);
        check("bp.ready1", 32'(in_ready), 32'd1);
        in_code = 4'b1000;
        tick();
        check("bp.full_ready", 32'(in_ready), 32'd0);
        check_out("bp.hold", 1'b1, 2'd0, 1'b0, 1'b0);
        in_code = 4'b0010;  // offered while full: must be ignored
        tick();
        check_out("bp.hold2", 1'b1, 2'd0, 1'b0, 1'b0);
        check("bp.full_ready2", 32'(in_ready), 32'd0);
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        check_out("bp.second", 1'b1, 2'd3, 1'b0, 1'b0);
        tick();
        check("bp.empty", 32'(out_valid), 32'd0);
        check("bp.err_cnt", 32'(err_cnt), 32'd0);

        // zero and multi-bit codes, streamed back to back
        in_valid = 1'b1; in_code = 4'b0000;
        tick();
        check_out("zero", 1'b1, 2'd0, 1'b1, 1'b0);
        in_code = 4'b0110;
        tick();
        check_out("multi", 1'b1, 2'd2, 1'b0, 1'b1);
        check("multi.err_cnt", 32'(err_cnt), 32'd1);
        in_code = 4'b1011;
        tick();
        check_out("multi3", 1'b1, 2'd3, 1'b0, 1'b1);
        check("multi3.err_cnt", 32'(err_cnt), 32'd2);

        // saturation: 300 more error codes
        in_code = 4'b1111;
        for (int i = 0; i < 300; i++) begin
            tick();
        end
        check_out("sat", 1'b1, 2'd3, 1'b0, 1'b1);
        check("sat.err_cnt", 32'(err_cnt), 32'd255);
        tick();
        check("sat.hold", 32'(err_cnt), 32'd255);
        in_valid = 1'b0;
        tick();
        check("sat.drain", 32'(out_valid), 32'd0);
        tick();
        check("idle.err_cnt", 32'(err_cnt), 32'd255);

        // walking one-hot at full throughput
        in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_code = 4'b0001 << (i % 4);
            tick();
            check_out($sformatf("walk%0d", i), 1'b1, 2'(i % 4), 1'b0, 1'b0);
            check($sformatf("walk%0d.ready", i), 32'(in_ready), 32'd1);
        end
        in_valid = 1'b0;
        tick();
        check("walk.drain", 32'(out_valid), 32'd0);
        check("walk.err_cnt", 32'(err_cnt), 32'd255);

        // reset while full discards everything
        out_ready = 1'b0; in_valid = 1'b1; in_code = 4'b0001;
        tick();
        in_code = 4'b0010;
        tick();
        check("full.ready", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        resetn = 1'b0;
        #1;
        check("rst.ready_during", 32'(in_ready), 32'd0);
        @(negedge clk);
        tick();
        check_out("rst", 1'b0, 2'd0, 1'b0, 1'b0);
        check("rst.err_cnt", 32'(err_cnt), 32'd0);
        check("rst.ready", 32'(in_ready), 32'd0);
        resetn = 1'b1;
        #1;
        check("rst.release_ready", 32'(in_ready), 32'd1);
        check("rst.release_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        out_ready = 1'b1;
        tick();
        check("rst.no_ghost", 32'(out_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
